state_machine: RTL and testbench

- Single-shot duration timer FSM.
- A `go` pulse starts a run of DURATION counted cycles. The block then emits a one-cycle `done` pulse and returns to idle.
- `kill` aborts a run in progress. The FSM holds in ABORT until `kill` drops.
- Used as a generic job/timeout sequencer inside a larger control path.

---
 rtl/state_machine_pkg.sv | 14 +
 rtl/state_machine.sv | 67 ++++++
 tb/tb_state_machine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/state_machine_pkg.sv
// Shared types and default sizing for the single-shot duration timer FSM.
package state_machine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DURATION_DEF = 100;
    localparam int CNT_W_DEF    = 7;

endpackage

// File: rtl/state_machine.sv
// Single-shot duration timer: go starts a DURATION-cycle run ending in a one-cycle
// done pulse; kill aborts and holds in ABORT until released.
module state_machine
    import state_machine_pkg::*;
#(
    parameter int DURATION = DURATION_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic kill,
    output logic done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DURATION - 1);

    state_t             current_state;
    state_t             next_state_d;
    logic [CNT_W-1:0]   duration_cnt;
    logic [CNT_W-1:0]   duration_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state <= IDLE;
            duration_cnt  <= '0;
        end else begin
            current_state <= next_state_d;
            duration_cnt  <= duration_cnt_d;
        end
    end

    // Counter advances only while ACTIVE and below terminal count, so it never wraps.
    always_comb begin
        next_state_d   = current_state;
        duration_cnt_d = '0;
        case (current_state)
            IDLE: begin
                if (go) next_state_d = ACTIVE;
            end
            ACTIVE: begin
                if (kill) begin
                    next_state_d = ABORT;
                end else if (duration_cnt == CNT_LAST) begin
                    next_state_d   = FINISH;
                    duration_cnt_d = duration_cnt;
                end else begin
                    duration_cnt_d = duration_cnt + 1'b1;
                end
            end
            ABORT: begin
                if (!kill) next_state_d = IDLE;
            end
            FINISH: begin
                next_state_d = IDLE;
            end
            default: begin
                next_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        done = (current_state == FINISH);
    end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for the duration timer FSM with DURATION=100.
module tb_state_machine;
    import state_machine_pkg::*;

    localparam int D = 100;

    logic clk;
    logic rst;
    logic go;
    logic kill;
    logic done;

    int checks;
    int errors;
    int done_total;
    int done_snap;
    int act_cycles;
    int done_idx;

    state_machine #(.DURATION(D), .CNT_W(7)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .kill (kill),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_sm(input string tag, input state_t st, input int cnt, input int dn);
        check({tag, "_state"}, int'(dut.current_state), int'(st));
        check({tag, "_cnt"}, int'(dut.duration_cnt), cnt);
        check({tag, "_done"}, int'(done), dn);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_total = 0;
        rst  = 1'b1;
        go   = 1'b0;
        kill = 1'b0;
        #3;
        check_sm("reset", IDLE, 0, 0);
        #10;
        step();
        rst = 1'b0;
        step();
        check_sm("idle_after_reset", IDLE, 0, 0);

        // Normal run: count ACTIVE cycles and locate the done pulse.
        go = 1'b1;
        step();
        go = 1'b0;
        check_sm("run_start", ACTIVE, 0, 0);
        act_cycles = 1;
        done_idx   = -1;
        for (int i = 1; i < 110; i++) begin
            step();
            if (dut.current_state == ACTIVE) act_cycles++;
            if (done === 1'b1 && done_idx < 0) done_idx = i;
            if (i == 99) check("run_cnt99", int'(dut.duration_cnt), 99);
        end
        check("run_active_cycles", act_cycles, D);
        check("run_done_idx", done_idx, D);
        check("run_done_count", done_total, 1);
        check_sm("run_end", IDLE, 0, 0);

        // Early kill after 30 counts.
        done_snap = done_total;
        go = 1'b1;
        step();
        go = 1'b0;
        steps(30);
        check_sm("ekill_pre", ACTIVE, 30, 0);
        kill = 1'b1;
        step();
        kill = 1'b0;
        check_sm("ekill_abort", ABORT, 0, 0);
        step();
        check_sm("ekill_idle", IDLE, 0, 0);
        check("ekill_no_done", done_total, done_snap);

        // Held kill for 5 cycles after 50 counts.
        go = 1'b1;
        step();
        go = 1'b0;
        steps(50);
        check("hkill_pre_cnt", int'(dut.duration_cnt), 50);
        kill = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hkill_abort", int'(dut.current_state), int'(ABORT));
        end
        check("hkill_cnt", int'(dut.duration_cnt), 0);
        kill = 1'b0;
        step();
        check_sm("hkill_idle", IDLE, 0, 0);
        check("hkill_no_done", done_total, done_snap);

        // Kill alone in IDLE is ignored.
        kill = 1'b1;
        steps(3);
        kill = 1'b0;
        check_sm("idle_kill", IDLE, 0, 0);

        // Kill with go in IDLE starts; kill held next cycle aborts.
        go   = 1'b1;
        kill = 1'b1;
        step();
        go = 1'b0;
        check_sm("gokill_start", ACTIVE, 0, 0);
        step();
        kill = 1'b0;
        check_sm("gokill_abort", ABORT, 0, 0);
        step();
        check_sm("gokill_idle", IDLE, 0, 0);

        // Back-to-back runs with go mid-run and kill during FINISH.
        done_snap = done_total;
        go = 1'b1;
        step();
        go = 1'b0;
        steps(40);
        go = 1'b1;
        step();
        go = 1'b0;
        check_sm("midgo_ignored", ACTIVE, 41, 0);
        steps(59);
        check_sm("b2b_finish1", FINISH, 99, 1);
        step();
        check_sm("b2b_idle", IDLE, 0, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        check_sm("b2b_start2", ACTIVE, 0, 0);
        steps(99);
        check_sm("b2b_last", ACTIVE, 99, 0);
        step();
        check_sm("b2b_finish2", FINISH, 99, 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        check_sm("b2b_end", IDLE, 0, 0);
        step();
        check("b2b_done_pulses", done_total - done_snap, 2);

        // Async reset mid-run at count 40, between clock edges.
        done_snap = done_total;
        go = 1'b1;
        step();
        go = 1'b0;
        steps(40);
        check("areset_pre_cnt", int'(dut.duration_cnt), 40);
        #2;
        rst = 1'b1;
        #1;
        check_sm("areset_now", IDLE, 0, 0);
        step();
        rst = 1'b0;
        steps(110);
        check_sm("areset_after", IDLE, 0, 0);
        check("areset_no_done", done_total, done_snap);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
